// File: rtl/ad7946_pkg.sv
// Shared constants, FSM state type and frame helper for the AD7946 ADC emulator.
package ad7946_pkg;

  localparam int unsigned ADC_BITS   = 14;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned PAD_BITS   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StReady,
    StShift
  } state_e;

  // Conversion result as it appears on the wire: zero pad bits ahead of the MSB.
  function automatic logic [FRAME_BITS-1:0] to_frame(input logic [ADC_BITS-1:0] v);
    return {{PAD_BITS{1'b0}}, v};
  endfunction

endpackage

// File: rtl/ad7946_emulator_if.sv
// Serial control/data bus between an ADC controller (master) and the emulator (slave).
interface ad7946_emulator_if;

  logic pden;
  logic chsel;
  logic cs_n;
  logic sclk;
  logic sdo;

  modport master (
    output pden,
    output chsel,
    output cs_n,
    output sclk,
    input  sdo
  );

  modport slave (
    input  pden,
    input  chsel,
    input  cs_n,
    input  sclk,
    output sdo
  );

endinterface

// File: rtl/ad7946_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses on the synced value.
module ad7946_sync_edge #(
  parameter int unsigned Stages   = 2,
  parameter bit          ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q[0] <= d;
      for (int unsigned i = 1; i < Stages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[Stages-1];
    end
  end

  assign q    = sync_q[Stages-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/ad7946_emulator.sv
// Behavioural AD7946 emulator: cs_n rise starts a conversion, cs_n low + sclk falls shift the
// 16-bit frame out MSB first. All serial-side inputs are synchronized before use.
module ad7946_emulator
  import ad7946_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 160,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  ad7946_emulator_if.slave    bus,
  input  logic [ADC_BITS-1:0] ch0_data,
  input  logic [ADC_BITS-1:0] ch1_data,
  output logic [15:0]         frame_count,
  output logic                conv_err
);

  localparam int unsigned CntW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int unsigned BitW = $clog2(FRAME_BITS);
  localparam logic [CntW-1:0] ConvLoad = CntW'(CONV_CYCLES - 1);
  localparam logic [BitW-1:0] BitLoad  = BitW'(FRAME_BITS - 1);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic pden_s, pden_rise, pden_fall;
  logic chsel_s, chsel_rise, chsel_fall;

  ad7946_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(bus.cs_n), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  ad7946_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(bus.sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  ad7946_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_pden (
    .clk(clk), .rst_n(rst_n), .d(bus.pden), .q(pden_s), .rise(pden_rise), .fall(pden_fall)
  );
  ad7946_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_chsel (
    .clk(clk), .rst_n(rst_n), .d(bus.chsel), .q(chsel_s), .rise(chsel_rise), .fall(chsel_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{cs_s, sclk_s, sclk_rise, pden_rise, pden_fall, chsel_rise, chsel_fall};

  state_e                state_q;
  logic                  sdo_q;
  logic [15:0]           frame_count_q;
  logic                  conv_err_q;
  logic [ADC_BITS-1:0]   result_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [BitW-1:0]       bit_cnt_q;
  logic [CntW-1:0]       conv_cnt_q;
  logic                  conv_ch_q;

  // A rise coincident with a fall is a glitch and must not start a conversion.
  logic                  cs_start;
  logic [ADC_BITS-1:0]   sample;
  logic [FRAME_BITS-1:0] frame_old, frame_new;

  assign cs_start  = cs_rise & ~cs_fall;
  assign sample    = conv_ch_q ? ch1_data : ch0_data;
  assign frame_old = to_frame(result_q);
  assign frame_new = to_frame(sample);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      sdo_q         <= 1'b0;
      frame_count_q <= '0;
      conv_err_q    <= 1'b0;
      result_q      <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      conv_cnt_q    <= '0;
      conv_ch_q     <= 1'b0;
    end else begin
      conv_err_q <= 1'b0;
      if (pden_s) begin
        state_q <= StIdle;
        sdo_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            sdo_q <= 1'b0;
            if (cs_start) begin
              conv_ch_q  <= chsel_s;
              conv_cnt_q <= ConvLoad;
              state_q    <= StConvert;
            end
          end
          StConvert: begin
            if (conv_cnt_q == '0) begin
              result_q <= sample;
              if (cs_fall) begin
                shift_q   <= frame_new;
                bit_cnt_q <= BitLoad;
                sdo_q     <= frame_new[FRAME_BITS-1];
                state_q   <= StShift;
              end else begin
                state_q <= StReady;
              end
            end else if (cs_fall) begin
              // Early read: flag it and ship whatever the last good conversion left.
              conv_err_q <= 1'b1;
              shift_q    <= frame_old;
              bit_cnt_q  <= BitLoad;
              sdo_q      <= frame_old[FRAME_BITS-1];
              state_q    <= StShift;
            end else begin
              conv_cnt_q <= conv_cnt_q - 1'b1;
            end
          end
          StReady: begin
            if (cs_fall) begin
              shift_q   <= frame_old;
              bit_cnt_q <= BitLoad;
              sdo_q     <= frame_old[FRAME_BITS-1];
              state_q   <= StShift;
            end
          end
          StShift: begin
            if (cs_start) begin
              frame_count_q <= frame_count_q + 16'd1;
              conv_ch_q     <= chsel_s;
              conv_cnt_q    <= ConvLoad;
              sdo_q         <= 1'b0;
              state_q       <= StConvert;
            end else if (sclk_fall) begin
              if (bit_cnt_q != '0) begin
                shift_q   <= shift_q << 1;
                bit_cnt_q <= bit_cnt_q - 1'b1;
                sdo_q     <= shift_q[FRAME_BITS-2];
              end else begin
                // Past the last bit: hold the line low until the frame closes.
                shift_q <= '0;
                sdo_q   <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            sdo_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sdo     = sdo_q;
  assign frame_count = frame_count_q;
  assign conv_err    = conv_err_q;

endmodule

// File: tb/tb_ad7946_emulator.sv
// Directed + randomized bench for ad7946_emulator, checked against a frame-level reference model.
module tb_ad7946_emulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] ch0_data, ch1_data;
  logic [15:0] frame_count;
  logic        conv_err;

  ad7946_emulator_if bus ();

  ad7946_emulator #(.CONV_CYCLES(160), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .ch0_data(ch0_data),
    .ch1_data(ch1_data),
    .frame_count(frame_count),
    .conv_err(conv_err)
  );

  always #5 clk = ~clk;

  int unsigned total = 0, passed = 0, failed = 0;
  int unsigned err_pulses = 0, err_run = 0, err_run_max = 0, sdo_hi = 0;
  bit          watch_sdo = 1'b0;

  // Reference model: last converted value, expected frame count, whether a read frame is open.
  logic [13:0] exp_result;
  logic [15:0] exp_fc;
  bit          in_frame;

  always @(negedge clk) begin
    if (conv_err === 1'b1) begin
      if (err_run == 0) err_pulses++;
      err_run++;
      if (err_run > err_run_max) err_run_max = err_run;
    end else begin
      err_run = 0;
    end
    if (watch_sdo && bus.sdo !== 1'b0) sdo_hi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_frame(input int n);
    logic [15:0] f;
    f = {2'b00, exp_result};
    return f >> (16 - n);
  endfunction

  // cs_n rises (closing any open frame), conversion runs to completion, then inputs are scrambled.
  task automatic start_conv(input bit ch);
    bus.chsel = ch;
    cyc(4);
    bus.cs_n = 1'b1;
    if (in_frame) exp_fc++;
    in_frame = 1'b0;
    cyc(200);
    exp_result = ch ? ch1_data : ch0_data;
    ch0_data = 14'($urandom);
    ch1_data = 14'($urandom);
  endtask

  task automatic read_frame(input int n, output logic [15:0] word);
    word = '0;
    bus.cs_n = 1'b0;
    in_frame = 1'b1;
    cyc(8);
    for (int i = 0; i < n; i++) begin
      word = {word[14:0], bus.sdo};
      bus.sclk = 1'b1;
      cyc(4);
      bus.sclk = 1'b0;
      cyc(4);
    end
  endtask

  logic [15:0] w;
  int unsigned err0;
  bit          ch;

  initial begin
    bus.pden = 1'b0; bus.chsel = 1'b0; bus.cs_n = 1'b1; bus.sclk = 1'b0;
    ch0_data = 14'h2ABC; ch1_data = 14'($urandom);
    exp_result = '0; exp_fc = '0; in_frame = 1'b0;

    cyc(5);
    check("reset_sdo", 32'(bus.sdo), 32'd0);
    check("reset_fc", 32'(frame_count), 32'd0);
    check("reset_err", 32'(conv_err), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Plain ch0 frame
    bus.cs_n = 1'b0;
    cyc(6);
    start_conv(1'b0);
    read_frame(16, w);
    check("frame_ch0", 32'(w), 32'h2ABC);
    check("sdo_after16", 32'(bus.sdo), 32'd0);
    bus.sclk = 1'b1; cyc(4); bus.sclk = 1'b0; cyc(4);
    check("sdo_extra_sclk", 32'(bus.sdo), 32'd0);
    ch1_data = 14'h3FFF; ch0_data = 14'h0000;
    start_conv(1'b1);
    check("fc_first", 32'(frame_count), 32'd1);
    check("no_err_yet", 32'(err_pulses), 32'd0);

    // ch1 full scale
    read_frame(16, w);
    check("frame_ch1", 32'(w), 32'h3FFF);

    // Random frames
    for (int k = 0; k < 4; k++) begin
      ch0_data = 14'($urandom); ch1_data = 14'($urandom);
      ch = 1'($urandom_range(0, 1));
      start_conv(ch);
      check("rand_fc", 32'(frame_count), 32'(exp_fc));
      read_frame(16, w);
      check("rand_frame", 32'(w), 32'(exp_frame(16)));
    end

    // cs_n falls 50 cycles into a conversion
    err0 = err_pulses;
    bus.chsel = 1'b0;
    cyc(4);
    bus.cs_n = 1'b1;
    exp_fc++;
    in_frame = 1'b0;
    cyc(50);
    read_frame(16, w);
    check("early_err_pulses", err_pulses - err0, 32'd1);
    check("early_frame_prev", 32'(w), 32'(exp_frame(16)));
    start_conv(1'($urandom_range(0, 1)));
    check("early_fc", 32'(frame_count), 32'(exp_fc));

    // Short frame of 7 bits, then a full aligned frame
    read_frame(7, w);
    check("short_bits", 32'(w), 32'(exp_frame(7)));
    start_conv(1'($urandom_range(0, 1)));
    check("short_fc", 32'(frame_count), 32'(exp_fc));
    read_frame(16, w);
    check("after_short_frame", 32'(w), 32'(exp_frame(16)));

    // Power-down during a conversion
    bus.chsel = 1'b1;
    cyc(4);
    bus.cs_n = 1'b1;
    exp_fc++;
    in_frame = 1'b0;
    cyc(20);
    bus.pden = 1'b1;
    watch_sdo = 1'b1;
    cyc(200);
    bus.pden = 1'b0;
    cyc(10);
    bus.cs_n = 1'b0;
    cyc(10);
    watch_sdo = 1'b0;
    check("pden_sdo_low", sdo_hi, 32'd0);
    check("pden_fc", 32'(frame_count), 32'(exp_fc));
    err0 = err_pulses;
    bus.cs_n = 1'b1;
    cyc(30);
    read_frame(16, w);
    check("pden_result_kept", 32'(w), 32'(exp_frame(16)));
    check("pden_err_pulse", err_pulses - err0, 32'd1);
    start_conv(1'($urandom_range(0, 1)));
    check("pden_next_fc", 32'(frame_count), 32'(exp_fc));
    read_frame(16, w);
    check("pden_next_frame", 32'(w), 32'(exp_frame(16)));

    // Reset in the middle of a frame
    start_conv(1'($urandom_range(0, 1)));
    read_frame(9, w);
    check("pre_reset_bits", 32'(w), 32'(exp_frame(9)));
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    exp_fc = '0; exp_result = '0; in_frame = 1'b0;
    cyc(1);
    check("midreset_sdo", 32'(bus.sdo), 32'd0);
    check("midreset_fc", 32'(frame_count), 32'd0);
    start_conv(1'($urandom_range(0, 1)));
    check("post_reset_fc0", 32'(frame_count), 32'(exp_fc));
    read_frame(16, w);
    check("post_reset_frame", 32'(w), 32'(exp_frame(16)));
    start_conv(1'($urandom_range(0, 1)));
    check("post_reset_fc1", 32'(frame_count), 32'd1);

    check("err_width_max", err_run_max, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
